// File: rtl/hv_dvdt_pkg.sv
// Shared types and constants for the HV dv/dt trim calibration block.
// HV_DVDT_DLY_MEAS_EN adds the delay-measurement state to the state encoding.
package hv_dvdt_pkg;
  localparam int CODE_W      = 4;
  localparam int CNT_W       = 6;
  localparam int DLY_MAX_DEF = 63;
  localparam logic [CODE_W-1:0] VBN_RST = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ON_SAR  = 3'd1,
    ST_OFF_SAR = 3'd2,
    ST_DONE    = 3'd3
`ifdef HV_DVDT_DLY_MEAS_EN
    , ST_DLY_MEAS = 3'd4
`endif
  } state_e;
endpackage

// File: rtl/hv_dvdt_sar4.sv
// 4-bit SAR sequencer: one trial bit per SETTLE_CYC cycles, comparator sampled on the
// last settle cycle. o_last/o_result flag the bit-0 decision in that same cycle.
module hv_dvdt_sar4
  import hv_dvdt_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_clear,
  input  logic              i_cmp,
  output logic [CODE_W-1:0] o_trial,
  output logic              o_last,
  output logic [CODE_W-1:0] o_result
);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic [SW-1:0]     settle_r;
  logic [1:0]        bit_r;
  logic              run_r;
  logic [CODE_W-1:0] trial_r;
  logic              sample_s;
  logic [CODE_W-1:0] keep_s;

  // Current bit decision from the comparator
  always_comb begin
    sample_s      = run_r && (settle_r == SW'(SETTLE_CYC - 1));
    keep_s        = trial_r;
    keep_s[bit_r] = i_cmp;
  end

  assign o_trial  = trial_r;
  assign o_last   = sample_s && (bit_r == 2'd0);
  assign o_result = keep_s;

  // Bit pointer, settle counter and trial register; a restart overrides the final sample
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_r    <= 1'b0;
      bit_r    <= 2'd0;
      settle_r <= '0;
      trial_r  <= '0;
    end else if (i_clear) begin
      run_r    <= 1'b0;
      bit_r    <= 2'd0;
      settle_r <= '0;
      trial_r  <= '0;
    end else if (i_start) begin
      run_r    <= 1'b1;
      bit_r    <= 2'd3;
      settle_r <= '0;
      trial_r  <= 4'b1000;
    end else if (sample_s) begin
      settle_r <= '0;
      if (bit_r == 2'd0) begin
        run_r   <= 1'b0;
        trial_r <= '0;
      end else begin
        trial_r <= keep_s | (CODE_W'(1) << (bit_r - 2'd1));
        bit_r   <= bit_r - 2'd1;
      end
    end else if (run_r) begin
      settle_r <= settle_r + SW'(1);
    end else begin
      settle_r <= settle_r;
    end
  end
endmodule

// File: rtl/hv_dvdt_trim_cal.sv
// HV dv/dt trim calibration: on-path SAR, off-path SAR, optional delay measurement
// (macro HV_DVDT_DLY_MEAS_EN), then a one-cycle DONE that publishes the results.
module hv_dvdt_trim_cal
  import hv_dvdt_pkg::*;
#(
  parameter int CLK_M      = 4,
  parameter int SETTLE_CYC = (1000 * CLK_M + 999) / 1000,
  parameter int DLY_MAX    = DLY_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cal_start,
  input  logic              i_cal_abort,
  input  logic              i_cmp_out,
  input  logic              i_dly_fb,
  output logic [CODE_W-1:0] o_trial_code,
  output logic              o_cal_sel,
  output logic              o_dly_pulse,
  output logic [CODE_W-1:0] o_on_vbn,
  output logic [CODE_W-1:0] o_off_vbn,
  output logic [CNT_W-1:0]  o_cnt_del,
  output logic              o_cal_busy,
  output logic              o_cal_done,
  output logic              o_cal_err
);
  state_e            state_r, state_nxt_s;
  logic              sar_start_s, sar_clear_s, sar_last_s, timeout_s;
  logic [CODE_W-1:0] sar_result_s, sar_trial_s, off_load_s;
  logic [CODE_W-1:0] on_work_r, off_work_r, on_vbn_r, off_vbn_r;
  logic              busy_r, sel_r, done_r;

  hv_dvdt_sar4 #(.SETTLE_CYC(SETTLE_CYC)) u_sar (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (sar_start_s),
    .i_clear (sar_clear_s),
    .i_cmp   (i_cmp_out),
    .o_trial (sar_trial_s),
    .o_last  (sar_last_s),
    .o_result(sar_result_s)
  );

  // Next-state decode; abort wins over every other event in busy states
  always_comb begin
    state_nxt_s = state_r;
    sar_start_s = 1'b0;
    sar_clear_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_cal_start && !i_cal_abort) begin
          state_nxt_s = ST_ON_SAR;
          sar_start_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ON_SAR: begin
        if (i_cal_abort) begin
          state_nxt_s = ST_IDLE;
          sar_clear_s = 1'b1;
        end else if (sar_last_s) begin
          state_nxt_s = ST_OFF_SAR;
          sar_start_s = 1'b1;
        end else begin
          state_nxt_s = ST_ON_SAR;
        end
      end
      ST_OFF_SAR: begin
        if (i_cal_abort) begin
          state_nxt_s = ST_IDLE;
          sar_clear_s = 1'b1;
        end else if (sar_last_s) begin
`ifdef HV_DVDT_DLY_MEAS_EN
          state_nxt_s = ST_DLY_MEAS;
`else
          state_nxt_s = ST_DONE;
`endif
        end else begin
          state_nxt_s = ST_OFF_SAR;
        end
      end
`ifdef HV_DVDT_DLY_MEAS_EN
      ST_DLY_MEAS: begin
        if (i_cal_abort) begin
          state_nxt_s = ST_IDLE;
        end else if (i_dly_fb || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DLY_MEAS;
        end
      end
`endif
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sar_clear_s = 1'b1;
      end
    endcase
  end

  // State register and status flags registered from the next state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      sel_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      sel_r   <= (state_nxt_s == ST_OFF_SAR);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Without delay measurement the off code goes straight from the SAR into DONE
  assign off_load_s = (state_r == ST_OFF_SAR) ? sar_result_s : off_work_r;

  // Working codes and published results; results move only on entry to DONE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      on_work_r  <= '0;
      off_work_r <= '0;
      on_vbn_r   <= VBN_RST;
      off_vbn_r  <= VBN_RST;
    end else begin
      if (state_r == ST_ON_SAR && sar_last_s && !i_cal_abort) begin
        on_work_r <= sar_result_s;
      end
      if (state_r == ST_OFF_SAR && sar_last_s && !i_cal_abort) begin
        off_work_r <= sar_result_s;
      end
      if (state_nxt_s == ST_DONE) begin
        on_vbn_r  <= on_work_r;
        off_vbn_r <= off_load_s;
      end
    end
  end

`ifdef HV_DVDT_DLY_MEAS_EN
  logic [CNT_W-1:0] cnt_r, cnt_del_r;
  logic             pulse_r, err_r;

  assign timeout_s = (state_r == ST_DLY_MEAS) && !i_cal_abort && !i_dly_fb &&
                     (cnt_r == CNT_W'(DLY_MAX));

  // Delay counter starts at zero on the launch cycle and saturates at DLY_MAX
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r     <= '0;
      cnt_del_r <= '0;
      pulse_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      pulse_r <= (state_nxt_s == ST_DLY_MEAS) && (state_r != ST_DLY_MEAS);
      if (state_nxt_s == ST_DLY_MEAS && state_r != ST_DLY_MEAS) begin
        cnt_r <= '0;
      end else if (state_r == ST_DLY_MEAS && state_nxt_s == ST_DLY_MEAS) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (state_r == ST_IDLE && state_nxt_s == ST_ON_SAR) begin
        err_r <= 1'b0;
      end else if (timeout_s) begin
        err_r <= 1'b1;
      end
      if (state_nxt_s == ST_DONE) begin
        cnt_del_r <= cnt_r;
      end
    end
  end

  assign o_dly_pulse = pulse_r;
  assign o_cnt_del   = cnt_del_r;
  assign o_cal_err   = err_r;
`else
  logic unused_fb_s;
  assign unused_fb_s = i_dly_fb;
  assign timeout_s   = 1'b0;
  assign o_dly_pulse = 1'b0;
  assign o_cnt_del   = '0;
  assign o_cal_err   = 1'b0;
`endif

  assign o_trial_code = sar_trial_s;
  assign o_cal_sel    = sel_r;
  assign o_on_vbn     = on_vbn_r;
  assign o_off_vbn    = off_vbn_r;
  assign o_cal_busy   = busy_r;
  assign o_cal_done   = done_r;
endmodule
